// File: rtl/umi_mem_agent.sv
// umi_mem_agent: UMI request endpoint backed by a byte-maskable synchronous word memory.
// Serves read/write requests with a single response and executes posted writes in the
// acceptance cycle. Illegal or unknown requests are dropped and counted.
module umi_mem_agent #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 64,
  parameter int unsigned CW    = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  output logic [15:0]   err_count
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);

  localparam logic [4:0] ReqRead   = 5'h01;
  localparam logic [4:0] ReqWrite  = 5'h03;
  localparam logic [4:0] ReqPosted = 5'h05;
  localparam logic [4:0] RespRead  = 5'h02;
  localparam logic [4:0] RespWrite = 5'h04;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] out_cmd_q, out_cmd_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [15:0]   err_q, err_d;

  logic [DW-1:0] mem [DEPTH];

  logic [15:0]      sel_cmd;
  logic [OW+IW-1:0] sel_addr;
  logic [DW-1:0]    sel_data;
  logic [16:0]      sel_nbytes;
  logic [16:0]      sel_off;
  logic             sel_fits;
  logic [NB-1:0]    sel_mask;
  logic [IW-1:0]    sel_idx;
  logic             mem_we;
  logic             accept;
  logic [15:0]      err_inc;

  // Beat geometry: the live request in IDLE, the latched request otherwise
  always_comb begin
    sel_cmd    = (state_q == StIdle) ? umi_in_cmd[15:0] : cmd_q[15:0];
    sel_addr   = (state_q == StIdle) ? umi_in_dstaddr[OW+IW-1:0] : dst_q[OW+IW-1:0];
    sel_data   = (state_q == StIdle) ? umi_in_data : data_q;
    sel_nbytes = (17'(sel_cmd[15:8]) + 17'd1) << sel_cmd[7:5];
    sel_off    = 17'(sel_addr[OW-1:0]);
    sel_fits   = (sel_off + sel_nbytes) <= 17'(NB);
    sel_idx    = sel_addr[OW +: IW];
    for (int b = 0; b < NB; b++) begin
      sel_mask[b] = (17'(b) >= sel_off) && (17'(b) < (sel_off + sel_nbytes));
    end
  end

  assign accept  = umi_in_valid && in_ready_q;
  assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  // Next-state and registered-output logic for the request/response FSM
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cmd_d       = cmd_q;
    dst_d       = dst_q;
    src_d       = src_q;
    data_d      = data_q;
    out_cmd_d   = out_cmd_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (accept) begin
          cmd_d  = umi_in_cmd;
          dst_d  = umi_in_dstaddr;
          src_d  = umi_in_srcaddr;
          data_d = umi_in_data;
          if (!sel_fits) begin
            err_d = err_inc;
          end else begin
            case (umi_in_cmd[4:0])
              ReqRead: begin
                state_d    = StRd;
                in_ready_d = 1'b0;
                out_cmd_d  = {umi_in_cmd[CW-1:5], RespRead};
              end
              ReqWrite: begin
                state_d    = StWr;
                in_ready_d = 1'b0;
                out_cmd_d  = {umi_in_cmd[CW-1:5], RespWrite};
              end
              ReqPosted: mem_we = 1'b1;
              default:   err_d  = err_inc;
            endcase
          end
        end
      end
      StRd: begin
        out_data_d  = mem[sel_idx];
        out_valid_d = 1'b1;
        state_d     = StResp;
      end
      StWr: begin
        mem_we      = 1'b1;
        out_data_d  = '0;
        out_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (umi_out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cmd_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      data_q      <= '0;
      out_cmd_q   <= '0;
      out_data_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cmd_q       <= cmd_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      data_q      <= data_d;
      out_cmd_q   <= out_cmd_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Byte-masked memory write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_mask[b]) mem[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  assign umi_in_ready    = in_ready_q;
  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  // Response addresses are the request addresses swapped
  assign umi_out_dstaddr = src_q;
  assign umi_out_srcaddr = dst_q;
  assign umi_out_data    = out_data_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_umi_mem_agent.sv
// tb_umi_mem_agent: table-driven directed checks of umi_mem_agent (DW=32, DEPTH=256)
// plus hand-written backpressure, posted streaming/wrap and reset-during-response sequences.
module tb_umi_mem_agent;

  localparam logic [4:0] ReqRead   = 5'h01;
  localparam logic [4:0] ReqWrite  = 5'h03;
  localparam logic [4:0] ReqPosted = 5'h05;
  localparam logic [4:0] RespRead  = 5'h02;
  localparam logic [4:0] RespWrite = 5'h04;

  logic        clk = 1'b0;
  logic        reset;
  logic        umi_in_valid;
  logic [31:0] umi_in_cmd;
  logic [63:0] umi_in_dstaddr;
  logic [63:0] umi_in_srcaddr;
  logic [31:0] umi_in_data;
  logic        umi_in_ready;
  logic        umi_out_valid;
  logic [31:0] umi_out_cmd;
  logic [63:0] umi_out_dstaddr;
  logic [63:0] umi_out_srcaddr;
  logic [31:0] umi_out_data;
  logic        umi_out_ready;
  logic [15:0] err_count;

  int n_total = 0;
  int n_pass  = 0;

  umi_mem_agent #(
    .DW   (32),
    .AW   (64),
    .CW   (32),
    .DEPTH(256)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .umi_in_valid   (umi_in_valid),
    .umi_in_cmd     (umi_in_cmd),
    .umi_in_dstaddr (umi_in_dstaddr),
    .umi_in_srcaddr (umi_in_srcaddr),
    .umi_in_data    (umi_in_data),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_cmd    (umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr),
    .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data   (umi_out_data),
    .umi_out_ready  (umi_out_ready),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [31:0] data;
    bit          resp;
    logic [4:0]  exp_op;
    logic [31:0] exp_data;
    logic [15:0] exp_err;
  } vec_t;

  function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                         input logic [7:0] len);
    return {16'h0, len, size, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait (bounded) for its acceptance edge; returns one cycle later
  task automatic send(input string name, input logic [31:0] cmd, input logic [63:0] dst,
                      input logic [63:0] src, input logic [31:0] data);
    int n;
    n = 0;
    umi_in_valid   = 1'b1;
    umi_in_cmd     = cmd;
    umi_in_dstaddr = dst;
    umi_in_srcaddr = src;
    umi_in_data    = data;
    while (!umi_in_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, " accept"}, umi_in_ready, 1'b1);
    tick();
    umi_in_valid = 1'b0;
  endtask

  task automatic transact(input string name, input vec_t v);
    send(name, v.cmd, v.dst, v.src, v.data);
    if (v.resp) begin
      check({name, " no early valid"}, umi_out_valid, 1'b0);
      tick();
      check({name, " valid"}, umi_out_valid, 1'b1);
      check({name, " cmd"}, umi_out_cmd, {v.cmd[31:5], v.exp_op});
      check({name, " dstaddr"}, umi_out_dstaddr, v.src);
      check({name, " srcaddr"}, umi_out_srcaddr, v.dst);
      check({name, " data"}, umi_out_data, v.exp_data);
      tick();
      check({name, " valid drop"}, umi_out_valid, 1'b0);
    end else begin
      check({name, " no resp"}, umi_out_valid, 1'b0);
      check({name, " ready kept"}, umi_in_ready, 1'b1);
    end
    check({name, " err_count"}, err_count, v.exp_err);
  endtask

  vec_t vecs[12];
  vec_t v;
  int   bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{mk_cmd(ReqWrite, 3'd2, 8'd0), 64'h10, 64'h1000_0000_0000_00A0, 32'hDEADBEEF,
                 1'b1, RespWrite, 32'h0, 16'd0};
    vecs[1]  = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h10, 64'h55, 32'h0,
                 1'b1, RespRead, 32'hDEADBEEF, 16'd0};
    vecs[2]  = '{mk_cmd(ReqWrite, 3'd2, 8'd0), 64'h0, 64'h66, 32'h11223344,
                 1'b1, RespWrite, 32'h0, 16'd0};
    vecs[3]  = '{mk_cmd(ReqPosted, 3'd0, 8'd0), 64'h2, 64'h66, 32'h00AA0000,
                 1'b0, 5'h0, 32'h0, 16'd0};
    vecs[4]  = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h0, 64'h67, 32'h0,
                 1'b1, RespRead, 32'h11AA3344, 16'd0};
    vecs[5]  = '{mk_cmd(ReqWrite, 3'd2, 8'd1), 64'h20, 64'h68, 32'h12345678,
                 1'b0, 5'h0, 32'h0, 16'd1};
    vecs[6]  = '{mk_cmd(5'h1F, 3'd2, 8'd0), 64'h24, 64'h69, 32'h0,
                 1'b0, 5'h0, 32'h0, 16'd2};
    vecs[7]  = '{mk_cmd(ReqPosted, 3'd1, 8'd0), 64'h3, 64'h6A, 32'hFFFFFFFF,
                 1'b0, 5'h0, 32'h0, 16'd3};
    vecs[8]  = '{mk_cmd(ReqWrite, 3'd2, 8'd0), 64'h44, 64'h70, 32'hCAFEF00D,
                 1'b1, RespWrite, 32'h0, 16'd3};
    vecs[9]  = '{mk_cmd(ReqWrite, 3'd1, 8'd0) | 32'h8040_0000, 64'h46, 64'h71, 32'h12340000,
                 1'b1, RespWrite, 32'h0, 16'd3};
    vecs[10] = '{mk_cmd(ReqRead, 3'd0, 8'd0) | 32'h0040_0000, 64'h45, 64'h72, 32'h0,
                 1'b1, RespRead, 32'h1234F00D, 16'd3};
    vecs[11] = '{mk_cmd(ReqRead, 3'd1, 8'd1), 64'h1_0000_0044, 64'h73, 32'h0,
                 1'b1, RespRead, 32'h1234F00D, 16'd3};

    reset          = 1'b1;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b1;
    repeat (3) tick();
    check("reset in_ready", umi_in_ready, 1'b0);
    check("reset out_valid", umi_out_valid, 1'b0);
    check("reset err_count", err_count, 16'd0);
    check("reset out_cmd", umi_out_cmd, 32'h0);
    check("reset out_dstaddr", umi_out_dstaddr, 64'h0);
    check("reset out_data", umi_out_data, 32'h0);
    reset = 1'b0;
    tick();
    check("post-reset in_ready", umi_in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      transact($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: response held stable for 5 cycles, then exactly one handshake
    umi_out_ready = 1'b0;
    send("bp", mk_cmd(ReqRead, 3'd2, 8'd0), 64'h44, 64'h77, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp valid %0d", i), umi_out_valid, 1'b1);
      check($sformatf("bp cmd %0d", i), umi_out_cmd, mk_cmd(RespRead, 3'd2, 8'd0));
      check($sformatf("bp dst %0d", i), umi_out_dstaddr, 64'h77);
      check($sformatf("bp data %0d", i), umi_out_data, 32'h1234F00D);
      check($sformatf("bp in_ready %0d", i), umi_in_ready, 1'b0);
      tick();
    end
    umi_out_ready = 1'b1;
    tick();
    check("bp released", umi_out_valid, 1'b0);
    tick();
    check("bp single handshake", umi_out_valid, 1'b0);
    check("bp idle ready", umi_in_ready, 1'b1);

    // Posted streaming over every word, then an aliasing write at 0x400
    bad = 0;
    for (int i = 0; i <= 256; i++) begin
      umi_in_valid   = 1'b1;
      umi_in_cmd     = mk_cmd(ReqPosted, 3'd2, 8'd0);
      umi_in_dstaddr = (i == 256) ? 64'h400 : 64'(4 * i);
      umi_in_srcaddr = 64'h0;
      umi_in_data    = (i == 256) ? 32'h5A5A5A5A : 32'(i);
      if (!umi_in_ready) bad++;
      tick();
    end
    check("stream ready stalls", 64'(bad), 64'd0);
    // Read issued the cycle right after the last posted write
    v = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h0, 64'h80, 32'h0, 1'b1, RespRead, 32'h5A5A5A5A,
          16'd3};
    transact("wrap word0", v);
    v = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h14, 64'h81, 32'h0, 1'b1, RespRead, 32'd5, 16'd3};
    transact("stream word5", v);
    v = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h3FC, 64'h82, 32'h0, 1'b1, RespRead, 32'd255, 16'd3};
    transact("stream word255", v);

    // Reset while a response is pending drops it and clears the error count
    umi_out_ready = 1'b0;
    send("rst", mk_cmd(ReqWrite, 3'd2, 8'd0), 64'h8, 64'h90, 32'h0BADF00D);
    tick();
    check("rst pending valid", umi_out_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("rst drops valid", umi_out_valid, 1'b0);
    check("rst clears err", err_count, 16'd0);
    check("rst in_ready", umi_in_ready, 1'b0);
    check("rst out_cmd", umi_out_cmd, 32'h0);
    reset         = 1'b0;
    umi_out_ready = 1'b1;
    tick();
    check("rst then ready", umi_in_ready, 1'b1);
    v = '{mk_cmd(ReqWrite, 3'd2, 8'd0), 64'h8, 64'h91, 32'h600DCAFE, 1'b1, RespWrite, 32'h0,
          16'd0};
    transact("after rst write", v);
    v = '{mk_cmd(ReqRead, 3'd2, 8'd0), 64'h8, 64'h92, 32'h0, 1'b1, RespRead, 32'h600DCAFE,
          16'd0};
    transact("after rst read", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
